// File: rtl/rotsq_pkg.sv
// rotsq_pkg: shared segment encoding and digit/position constants for the
// rotating-square generator and the raw-segment display mux.
// Segment bytes are {dp,a,b,c,d,e,f,g}, active low (0 = lit); dp is never lit.
package rotsq_pkg;

    localparam int NUM_POS = 8;
    localparam int NUM_DIG = 4;

    typedef enum int {
        SEG_BIT_G  = 0,
        SEG_BIT_F  = 1,
        SEG_BIT_E  = 2,
        SEG_BIT_D  = 3,
        SEG_BIT_C  = 4,
        SEG_BIT_B  = 5,
        SEG_BIT_A  = 6,
        SEG_BIT_DP = 7
    } seg_bit_e;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_UP  = 8'h9C;
    localparam seg_t SEG_DN  = 8'hE2;
    localparam seg_t SEG_OFF = 8'hFF;

    // Upper square walks digits 3..0 for p=0..3 (digit = ~p[1:0]);
    // lower square walks digits 0..3 for p=4..7 (digit = p[1:0]).
    function automatic seg_t pos_seg(input logic [2:0] p, input logic [1:0] d);
        return (d == (p[2] ? p[1:0] : ~p[1:0])) ? (p[2] ? SEG_DN : SEG_UP) : SEG_OFF;
    endfunction

endpackage

// File: rtl/rotsq_pattern_gen_tick.sv
// mod_m_tick: modulo-M enabled prescaler producing a one-cycle tick.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (count -> 0)
//   en    - count advances only while high; holds otherwise
//   clr   - synchronous restart of the count, overrides en
//   tick  - high for the enabled cycle in which count is at its terminal value
//   count - current prescaler count 0..M-1
module mod_m_tick #(
    parameter  int M = 4,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic         tick,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // >= rather than == so an out-of-range count wraps on the next enabled cycle
    assign tick    = en && (count_q >= W'(M - 1));
    assign count_d = clr ? '0 : tick ? '0 : en ? count_q + W'(1) : count_q;
    assign count   = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/rotsq_pattern_gen.sv
// rotsq_pattern_gen: rotating-square animation as four raw active-low segment bytes.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   en      - 1 = animation advances, 0 = paused
//   cw      - 1 = position increments, 0 = decrements (sampled on step)
//   clr     - synchronous restart of position and prescaler
//   blank   - forces all digits off and active low one cycle later
//   in3..in0- registered segment bytes, digit 3 leftmost
//   active  - registered ~blank
//   pos     - current animation position 0..7
module rotsq_pattern_gen
    import rotsq_pkg::*;
#(
    parameter  int TICK_DIV = 25000000,
    localparam int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cw,
    input  logic       clr,
    input  logic       blank,
    output logic [7:0] in3,
    output logic [7:0] in2,
    output logic [7:0] in1,
    output logic [7:0] in0,
    output logic       active,
    output logic [2:0] pos
);

    logic             step;
    logic [CNT_W-1:0] cnt_unused;
    logic [2:0]       pos_q, pos_d;
    seg_t             seg_q [NUM_DIG];
    seg_t             seg_d [NUM_DIG];
    logic             active_q;

    mod_m_tick #(.M(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .tick  (step),
        .count (cnt_unused)
    );

    assign pos_d = clr ? 3'd0 : step ? (cw ? pos_q + 3'd1 : pos_q - 3'd1) : pos_q;

    // Decode from the next-state position so segments move on the same edge as pos
    always_comb begin
        for (int i = 0; i < NUM_DIG; i++) seg_d[i] = blank ? SEG_OFF : pos_seg(pos_d, 2'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q    <= 3'd0;
            active_q <= 1'b1;
            for (int i = 0; i < NUM_DIG; i++) seg_q[i] <= pos_seg(3'd0, 2'(i));
        end else begin
            pos_q    <= pos_d;
            active_q <= ~blank;
            for (int i = 0; i < NUM_DIG; i++) seg_q[i] <= seg_d[i];
        end
    end

    assign in3    = seg_q[3];
    assign in2    = seg_q[2];
    assign in1    = seg_q[1];
    assign in0    = seg_q[0];
    assign active = active_q;
    assign pos    = pos_q;

endmodule

// File: tb/tb_rotsq_pattern_gen.sv
// tb_rotsq_pattern_gen: directed bench with a per-cycle behavioural model and literal pins.
module tb_rotsq_pattern_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, en, cw, clr, blank;
    logic [7:0] in3, in2, in1, in0;
    logic       active;
    logic [2:0] pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotsq_pattern_gen #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .cw     (cw),
        .clr    (clr),
        .blank  (blank),
        .in3    (in3),
        .in2    (in2),
        .in1    (in1),
        .in0    (in0),
        .active (active),
        .pos    (pos)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: interval counter, position, delayed blank
    int m_cnt, m_pos;
    bit m_blank;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_pos   <= 0;
            m_blank <= 0;
        end else begin
            m_blank <= blank;
            if (clr) begin
                m_cnt <= 0;
                m_pos <= 0;
            end else if (en) begin
                if (m_cnt >= TD - 1) begin
                    m_cnt <= 0;
                    m_pos <= (m_pos + (cw ? 1 : 7)) % 8;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_seg(input int p, input int d, input bit b);
        if (b) return 8'hFF;
        if (p < 4) return (d == 3 - p) ? 8'h9C : 8'hFF;
        return (d == p - 4) ? 8'hE2 : 8'hFF;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_in3", in3, exp_seg(m_pos, 3, m_blank));
            chk("model_in2", in2, exp_seg(m_pos, 2, m_blank));
            chk("model_in1", in1, exp_seg(m_pos, 1, m_blank));
            chk("model_in0", in0, exp_seg(m_pos, 0, m_blank));
            chk("model_active", active, !m_blank);
            chk("model_pos", pos, m_pos[2:0]);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in3"}, in3, 8'h9C);
        chk({tag, "_in2"}, in2, 8'hFF);
        chk({tag, "_in1"}, in1, 8'hFF);
        chk({tag, "_in0"}, in0, 8'hFF);
        chk({tag, "_active"}, active, 1'b1);
        chk({tag, "_pos"}, pos, 3'd0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; cw = 1'b1; clr = 1'b0; blank = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        edges(3);  chk("no_step_yet", pos, 3'd0);
        edges(1);  chk("p1", pos, 3'd1); chk("p1_in2", in2, 8'h9C);
                   chk("p1_in3", in3, 8'hFF); chk("p1_in0", in0, 8'hFF);
        edges(4);  chk("p2", pos, 3'd2);
        edges(4);  chk("p3", pos, 3'd3); chk("p3_in0", in0, 8'h9C);
        edges(4);  chk("p4", pos, 3'd4); chk("p4_in0", in0, 8'hE2);
        edges(12); chk("p7", pos, 3'd7); chk("p7_in3", in3, 8'hE2);
        edges(4);  chk("wrap0", pos, 3'd0); chk("wrap0_in3", in3, 8'h9C);
        cw = 1'b0;
        edges(4);  chk("ccw7", pos, 3'd7); chk("ccw7_in3", in3, 8'hE2);
        edges(1);  cw = 1'b1;
        edges(1);  cw = 1'b0;
        edges(2);  chk("ccw6", pos, 3'd6);
        cw = 1'b1;
        edges(4);  chk("cw7", pos, 3'd7);
        edges(2);  en = 1'b0;
        edges(10); chk("pause_hold", pos, 3'd7);
        en = 1'b1;
        edges(1);  chk("resume_1", pos, 3'd7);
        edges(1);  chk("resume_2", pos, 3'd0);
        edges(20); chk("p5", pos, 3'd5);
        edges(3);  clr = 1'b1;
        edges(1);  clr = 1'b0;
        chk("clr_pos", pos, 3'd0); chk("clr_in3", in3, 8'h9C); chk("clr_in0", in0, 8'hFF);
        edges(3);  chk("clr_wait", pos, 3'd0);
        edges(1);  chk("clr_step", pos, 3'd1);
        edges(4);  chk("pre_blank", pos, 3'd2);
        blank = 1'b1;
        edges(1);  chk("blk_in3", in3, 8'hFF); chk("blk_in2", in2, 8'hFF);
                   chk("blk_in1", in1, 8'hFF); chk("blk_in0", in0, 8'hFF);
                   chk("blk_active", active, 1'b0);
        edges(3);  chk("blk_pos", pos, 3'd3); chk("blk_in0_step", in0, 8'hFF);
        edges(2);  blank = 1'b0;
        edges(1);  chk("unblk_in0", in0, 8'h9C); chk("unblk_active", active, 1'b1);
                   chk("unblk_pos", pos, 3'd3);
        edges(1);  chk("p4b", pos, 3'd4);
        edges(8);  chk("p6", pos, 3'd6);
        edges(2);
        #3 reset = 1'b1;
        #1 chk_reset_vals("async");
        @(posedge clk); #1;
        reset = 1'b0;
        edges(3);  chk("rst2_wait", pos, 3'd0);
        edges(1);  chk("rst2_step", pos, 3'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
